// File: rtl/proc_mc.sv
// proc_mc: parametrised multi-cycle 16-bit-instruction core with a valid/ready output stream.
// Optional macro PROC_MC_ILLEGAL_TRAP_EN: unlisted opcodes trap (err=1, halted=1) instead of acting as NOPs.
module proc_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       fromMem,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       toMem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic              err
);
  localparam int IDX_W = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_MEM_READ = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_WRITE    = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s, addr_r, addr_s, pc_inc_s;
  logic [15:0]       ir_r, ir_s, to_mem_r, to_mem_s;
  logic              we_r, we_s, out_valid_r, out_valid_s, halted_r, halted_s;
  logic [DATA_W-1:0] out_data_r, out_data_s;
  logic [DATA_W-1:0] regs_r [NREGS];
  logic              rf_we_s;
  logic [IDX_W-1:0]  rf_idx_s, rd_s, ra_s, rb_s;
  logic [DATA_W-1:0] rf_data_s, ra_val_s, rb_val_s;
  logic              is_halt_s, is_ldi_s;
  logic [4:0]        opc_s;
`ifdef PROC_MC_ILLEGAL_TRAP_EN
  logic              err_r, err_s;
`endif

  // Index fields keep only the low log2(NREGS) bits; upper bits are ignored.
  assign is_halt_s = (ir_r == 16'h7777);
  assign is_ldi_s  = (ir_r[15:13] == 3'b110);
  assign opc_s     = ir_r[15:11];
  assign rd_s      = ir_r[8 +: IDX_W];
  assign ra_s      = ir_r[6 +: IDX_W];
  assign rb_s      = ir_r[0 +: IDX_W];
  assign ra_val_s  = regs_r[ra_s];
  assign rb_val_s  = regs_r[rb_s];
  assign pc_inc_s  = pc_r + ADDR_W'(1'b1);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ir_s        = ir_r;
    addr_s      = addr_r;
    to_mem_s    = to_mem_r;
    we_s        = we_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    halted_s    = halted_r;
`ifdef PROC_MC_ILLEGAL_TRAP_EN
    err_s       = err_r;
`endif
    rf_we_s     = 1'b0;
    rf_idx_s    = rd_s;
    rf_data_s   = DATA_W'(ir_r[7:0]);
    case (state_r)
      S_FETCH: begin
        addr_s  = pc_r;
        we_s    = 1'b0;
        state_s = S_DECODE;
      end
      S_DECODE: begin
        ir_s    = fromMem;
        state_s = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_halt_s) begin
          halted_s = 1'b1;
          state_s  = S_HALT;
        end else if (is_ldi_s) begin
          rf_we_s = 1'b1;
          pc_s    = pc_inc_s;
          state_s = S_FETCH;
        end else begin
          case (opc_s)
            5'd1: begin
              addr_s  = ADDR_W'(ir_r[10:0]);
              state_s = S_MEM_READ;
            end
            5'd2: begin
              out_data_s  = rb_val_s;
              out_valid_s = 1'b1;
              state_s     = S_OUT_WAIT;
            end
            5'd3: begin
              rf_we_s   = 1'b1;
              rf_idx_s  = ra_s;
              rf_data_s = ra_val_s + rb_val_s;
              pc_s      = pc_inc_s;
              state_s   = S_FETCH;
            end
            5'd4: begin
              we_s     = 1'b1;
              addr_s   = ADDR_W'(16'(rb_val_s));
              to_mem_s = 16'(ra_val_s);
              state_s  = S_WRITE;
            end
            default: begin
`ifdef PROC_MC_ILLEGAL_TRAP_EN
              // pc stays on the offending instruction for post-mortem inspection.
              err_s    = 1'b1;
              halted_s = 1'b1;
              state_s  = S_HALT;
`else
              pc_s    = pc_inc_s;
              state_s = S_FETCH;
`endif
            end
          endcase
        end
      end
      S_MEM_READ: begin
        out_data_s  = fromMem[DATA_W-1:0];
        out_valid_s = 1'b1;
        state_s     = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          pc_s        = pc_inc_s;
          state_s     = S_FETCH;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      S_WRITE: begin
        we_s    = 1'b0;
        pc_s    = pc_inc_s;
        state_s = S_FETCH;
      end
      S_HALT: begin
        we_s    = 1'b0;
        state_s = S_HALT;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_FETCH;
      pc_r        <= {ADDR_W{1'b0}};
      ir_r        <= 16'h0000;
      addr_r      <= {ADDR_W{1'b0}};
      to_mem_r    <= 16'h0000;
      we_r        <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      halted_r    <= 1'b0;
`ifdef PROC_MC_ILLEGAL_TRAP_EN
      err_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ir_r        <= ir_s;
      addr_r      <= addr_s;
      to_mem_r    <= to_mem_s;
      we_r        <= we_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      halted_r    <= halted_s;
`ifdef PROC_MC_ILLEGAL_TRAP_EN
      err_r       <= err_s;
`endif
    end
  end

  // Register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (rf_we_s) begin
      regs_r[rf_idx_s] <= rf_data_s;
    end
  end

  assign we        = we_r;
  assign addr      = addr_r;
  assign toMem     = to_mem_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign halted    = halted_r;
`ifdef PROC_MC_ILLEGAL_TRAP_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_proc_mc.sv
// Self-checking bench for proc_mc (DATA_W=8, ADDR_W=16, NREGS=32): program table plus
// hand-written backpressure, store, halt, mid-run reset and (optionally) trap sequences.
module tb_proc_mc;
  logic        clk, rst, we, out_valid, out_ready, halted, err;
  logic [15:0] fromMem, addr, toMem;
  logic [7:0]  out_data;
  logic [15:0] mem [0:65535];
  int          checks = 0;
  int          errors = 0;

`ifdef PROC_MC_ILLEGAL_TRAP_EN
  localparam logic [15:0] NOP_W = 16'hC000;
`else
  localparam logic [15:0] NOP_W = 16'h0000;
`endif

  typedef struct {
    string            name;
    logic [5:0][15:0] prog;
    logic [15:0]      daddr;
    logic [15:0]      dval;
    logic [7:0]       exp_out;
    int               exp_lat;
    logic [15:0]      exp_halt_pc;
  } vec_t;

  vec_t vecs [8];

  proc_mc dut (
    .clk(clk), .rst(rst), .fromMem(fromMem), .we(we), .addr(addr), .toMem(toMem),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .halted(halted), .err(err)
  );

  assign fromMem = mem[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[addr] <= toMem;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [5:0][15:0] p, input logic [15:0] da, input logic [15:0] dv);
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[da] = dv;
    for (int i = 0; i < 6; i++) mem[i] = p[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs", {we, addr, toMem, out_valid, out_data, halted, err}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        cyc = c + 1;
        break;
      end
    end
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (halted) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit          ok;
    int          cyc, cnt;
    logic [15:0] wa, wd, haddr;

    // LDI rd,imm = 110_ddddd_iiiiiiii; OUTLOC = 0x0800|loc; OUTR = 0x1000|rs;
    // ADD = 0x1800|(rd<<6)|rs; STR = 0x2000|(rdata<<6)|raddr; HALT = 0x7777.
    vecs[0] = '{"ldi_outr",   {16'h0, 16'h0, 16'h0, 16'h7777, 16'h1003, 16'hC3A5}, 16'h0000, 16'h0000, 8'hA5, 6,  16'd2};
    vecs[1] = '{"add",        {16'h0, 16'h7777, 16'h1001, 16'h1842, 16'hC220, 16'hC1F0}, 16'h0000, 16'h0000, 8'h10, 12, 16'd4};
    vecs[2] = '{"outloc",     {16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 16'h0840}, 16'h0040, 16'h1234, 8'h34, 4,  16'd1};
    vecs[3] = '{"add_self",   {16'h0, 16'h0, 16'h7777, 16'h1007, 16'h19C7, 16'hC741}, 16'h0000, 16'h0000, 8'h82, 9,  16'd3};
    vecs[4] = '{"nop",        {16'h0, 16'h0, 16'h7777, 16'h1002, NOP_W, 16'hC211}, 16'h0000, 16'h0000, 8'h11, 9,  16'd3};
    vecs[5] = '{"reg_reset",  {16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 16'h1009}, 16'h0000, 16'h0000, 8'h00, 3,  16'd1};
    vecs[6] = '{"outloc_max", {16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 16'h0FFF}, 16'h07FF, 16'hBEEF, 8'hEF, 4,  16'd1};
    vecs[7] = '{"add_wrap",   {16'h0, 16'h7777, 16'h1001, 16'h1842, 16'hC201, 16'hC1FF}, 16'h0000, 16'h0000, 8'h00, 12, 16'd4};

    rst = 1'b1;
    out_ready = 1'b1;

    foreach (vecs[v]) begin
      load_prog(vecs[v].prog, vecs[v].daddr, vecs[v].dval);
      out_ready = 1'b1;
      do_reset();
      wait_valid(ok, cyc);
      check({vecs[v].name, "_valid_seen"}, 64'(ok), 64'd1);
      check({vecs[v].name, "_latency"}, 64'(cyc), 64'(vecs[v].exp_lat));
      check({vecs[v].name, "_data"}, 64'(out_data), 64'(vecs[v].exp_out));
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
        if (!out_valid) break;
        cnt++;
        @(negedge clk);
      end
      check({vecs[v].name, "_valid_cycles"}, 64'(cnt), 64'd1);
      wait_halt(ok);
      check({vecs[v].name, "_halt_seen"}, 64'(ok), 64'd1);
      check({vecs[v].name, "_halt_pc"}, 64'(addr), 64'(vecs[v].exp_halt_pc));
      check({vecs[v].name, "_err"}, 64'(err), 64'd0);
    end

    // Backpressure: hold ready low for five cycles after valid rises.
    load_prog(vecs[0].prog, 16'h0000, 16'h0000);
    out_ready = 1'b0;
    do_reset();
    wait_valid(ok, cyc);
    check("bp_valid_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {out_valid, out_data, addr}, {1'b1, 8'hA5, 16'h0001});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_transfer", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("bp_next_fetch", 64'(addr), 64'd2);

    // Store: r4=0x55, r5=0x80, STR data r4 to address r5.
    load_prog({16'h0, 16'h0, 16'h7777, 16'h2105, 16'hC580, 16'hC455}, 16'h0000, 16'h0000);
    do_reset();
    cnt = 0;
    wa = 16'h0000;
    wd = 16'h0000;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (we) begin
        cnt++;
        wa = addr;
        wd = toMem;
      end
      if (halted) break;
    end
    check("str_we_cycles", 64'(cnt), 64'd1);
    check("str_addr", 64'(wa), 64'h0080);
    check("str_data", 64'(wd), 64'h0055);
    check("str_mem", 64'(mem[16'h0080]), 64'h0055);

    // Halt is terminal: addr frozen, no writes, no output.
    check("halt_sticky_start", 64'(halted), 64'd1);
    haddr = addr;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("halt_frozen", {halted, we, out_valid, addr}, {1'b1, 1'b0, 1'b0, haddr});
    end
    check("halt_addr", 64'(haddr), 64'd3);

    // Reset asserted while waiting in OUT_WAIT.
    load_prog(vecs[0].prog, 16'h0000, 16'h0000);
    out_ready = 1'b0;
    do_reset();
    wait_valid(ok, cyc);
    check("midrst_valid_seen", 64'(ok), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outputs", {we, addr, toMem, out_valid, out_data, halted, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_valid(ok, cyc);
    check("midrst_restart_lat", 64'(cyc), 64'd6);
    check("midrst_restart_data", {out_data, addr}, {8'hA5, 16'h0001});

`ifdef PROC_MC_ILLEGAL_TRAP_EN
    load_prog({16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 16'hF800}, 16'h0000, 16'h0000);
    do_reset();
    wait_halt(ok);
    check("trap_halt_seen", 64'(ok), 64'd1);
    check("trap_flags", {err, halted, addr}, {1'b1, 1'b1, 16'h0000});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
